// File: rtl/csr_to_dense.sv
// Streaming CSR-to-dense decoder: row pointers plus (value, column) entries in, dense N x N row-major out.
// Optional malformed-input checking is enabled by defining CSR_DECODE_CHECK_EN.
module csr_to_dense #(
    parameter int N      = 100,
    parameter int DATA_W = 32,
    parameter int PTR_W  = 16,
    parameter int COL_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              ptr_valid,
    output logic              ptr_ready,
    input  logic [PTR_W-1:0]  ptr_data,
    input  logic              ent_valid,
    output logic              ent_ready,
    input  logic [DATA_W-1:0] ent_val,
    input  logic [COL_W-1:0]  ent_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [COL_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic              out_row_last,
    output logic              out_last
);

`ifdef CSR_DECODE_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    localparam logic [COL_W-1:0] LAST_IDX = COL_W'(N - 1);
    localparam logic [COL_W:0]   N_EXT    = (COL_W + 1)'(N);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_BASE = 3'd1,
        S_ROW_PTR   = 3'd2,
        S_EMIT      = 3'd3,
        S_DRAIN     = 3'd4,
        S_FLUSH     = 3'd5
    } state_t;

    state_t             state_r, state_next_s;
    logic [PTR_W-1:0]   prev_ptr_r, remaining_r, rem_after_s;
    logic [COL_W-1:0]   row_r, col_r;
    logic               busy_r, done_r, err_r;
    logic               out_valid_r, out_row_last_r, out_last_r;
    logic [DATA_W-1:0]  out_data_r;
    logic [COL_W-1:0]   out_row_r, out_col_r;
    logic               can_load_s, load_s, load_zero_s, consume_s, bad_col_s;
    logic               err_set_s, row_adv_s, ptr_hs_s, start_s, finish_s, ptr_dec_s;
    logic               ptr_ready_s, ent_ready_s, rem_zero_s;

    // End-of-row successor: next row pointer, or flush after the final row.
    function automatic state_t row_end_state(input logic [COL_W-1:0] row);
        if (row == LAST_IDX) begin
            return S_FLUSH;
        end else begin
            return S_ROW_PTR;
        end
    endfunction

    // Next-state and per-cycle control decode.
    always_comb begin
        state_next_s = state_r;
        ptr_ready_s  = 1'b0;
        ent_ready_s  = 1'b0;
        load_s       = 1'b0;
        load_zero_s  = 1'b0;
        consume_s    = 1'b0;
        err_set_s    = 1'b0;
        row_adv_s    = 1'b0;
        ptr_hs_s     = 1'b0;
        start_s      = 1'b0;
        finish_s     = 1'b0;
        can_load_s   = !out_valid_r || out_ready;
        rem_zero_s   = (remaining_r == PTR_ZERO);
        ptr_dec_s    = (ptr_data < prev_ptr_r);
        bad_col_s    = CHECK_EN && (({1'b0, ent_col} >= N_EXT) || (ent_col < col_r));
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    start_s      = 1'b1;
                    state_next_s = S_LOAD_BASE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LOAD_BASE: begin
                ptr_ready_s = 1'b1;
                if (ptr_valid) begin
                    ptr_hs_s     = 1'b1;
                    state_next_s = S_ROW_PTR;
                end else begin
                    state_next_s = S_LOAD_BASE;
                end
            end
            S_ROW_PTR: begin
                ptr_ready_s = 1'b1;
                if (ptr_valid) begin
                    ptr_hs_s     = 1'b1;
                    err_set_s    = ptr_dec_s;
                    state_next_s = S_EMIT;
                end else begin
                    state_next_s = S_ROW_PTR;
                end
            end
            S_EMIT: begin
                if (!can_load_s) begin
                    load_s = 1'b0;
                end else if (rem_zero_s) begin
                    load_s      = 1'b1;
                    load_zero_s = 1'b1;
                end else if (!ent_valid) begin
                    load_s = 1'b0;
                end else if (bad_col_s) begin
                    consume_s = 1'b1;
                    err_set_s = 1'b1;
                end else if (ent_col > col_r) begin
                    load_s      = 1'b1;
                    load_zero_s = 1'b1;
                end else begin
                    // Lower columns reach here only with checking off; they are taken as a match.
                    load_s    = 1'b1;
                    consume_s = 1'b1;
                end
                ent_ready_s = consume_s;
                if (load_s && (col_r == LAST_IDX)) begin
                    if (rem_after_s != PTR_ZERO) begin
                        err_set_s    = 1'b1;
                        state_next_s = S_DRAIN;
                    end else begin
                        row_adv_s    = (row_r != LAST_IDX);
                        state_next_s = row_end_state(row_r);
                    end
                end else begin
                    state_next_s = S_EMIT;
                end
            end
            S_DRAIN: begin
                if (rem_zero_s) begin
                    row_adv_s    = (row_r != LAST_IDX);
                    state_next_s = row_end_state(row_r);
                end else begin
                    ent_ready_s  = 1'b1;
                    consume_s    = ent_valid;
                    state_next_s = S_DRAIN;
                end
            end
            S_FLUSH: begin
                if (can_load_s) begin
                    finish_s     = 1'b1;
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_FLUSH;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    assign rem_after_s = consume_s ? (remaining_r - PTR_ONE) : remaining_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Status flags, pointer bookkeeping and row/column counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            prev_ptr_r  <= PTR_ZERO;
            remaining_r <= PTR_ZERO;
            row_r       <= {COL_W{1'b0}};
            col_r       <= {COL_W{1'b0}};
        end else begin
            done_r <= finish_s;
            if (start_s) begin
                busy_r <= 1'b1;
            end else if (finish_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            if (start_s) begin
                err_r <= 1'b0;
            end else begin
                err_r <= CHECK_EN && (err_r || err_set_s);
            end
            if (ptr_hs_s) begin
                prev_ptr_r <= ptr_data;
                if (state_r == S_LOAD_BASE) begin
                    row_r <= {COL_W{1'b0}};
                end else begin
                    // A decreasing pointer yields an empty row rather than a huge wrapped count.
                    remaining_r <= ptr_dec_s ? PTR_ZERO : (ptr_data - prev_ptr_r);
                    col_r       <= {COL_W{1'b0}};
                end
            end else begin
                remaining_r <= rem_after_s;
                if (load_s) begin
                    col_r <= col_r + COL_W'(1);
                end
                if (row_adv_s) begin
                    row_r <= row_r + COL_W'(1);
                end
            end
        end
    end

    // Output element register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r    <= 1'b0;
            out_data_r     <= {DATA_W{1'b0}};
            out_row_r      <= {COL_W{1'b0}};
            out_col_r      <= {COL_W{1'b0}};
            out_row_last_r <= 1'b0;
            out_last_r     <= 1'b0;
        end else if (load_s) begin
            out_valid_r    <= 1'b1;
            out_data_r     <= load_zero_s ? {DATA_W{1'b0}} : ent_val;
            out_row_r      <= row_r;
            out_col_r      <= col_r;
            out_row_last_r <= (col_r == LAST_IDX);
            out_last_r     <= (col_r == LAST_IDX) && (row_r == LAST_IDX);
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign ptr_ready    = ptr_ready_s;
    assign ent_ready    = ent_ready_s;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_row      = out_row_r;
    assign out_col      = out_col_r;
    assign out_row_last = out_row_last_r;
    assign out_last     = out_last_r;

endmodule

// File: tb/tb_csr_to_dense.sv
// Table-driven scoreboard bench for csr_to_dense at N=4; expectations follow CSR_DECODE_CHECK_EN.
module tb_csr_to_dense;

    localparam int N = 4;

`ifdef CSR_DECODE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic        ptr_valid = 1'b0;
    logic        ptr_ready;
    logic [15:0] ptr_data = 16'd0;
    logic        ent_valid = 1'b0;
    logic        ent_ready;
    logic [31:0] ent_val = 32'd0;
    logic [1:0]  ent_col = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_row, out_col;
    logic        out_row_last, out_last;

    csr_to_dense #(.N(N), .DATA_W(32), .PTR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .ptr_valid(ptr_valid), .ptr_ready(ptr_ready), .ptr_data(ptr_data),
        .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_val(ent_val), .ent_col(ent_col),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_row_last(out_row_last), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        row_last;
        logic        last;
    } exp_t;

    typedef struct {
        string name;
        int    ptrs[5];
        int    vals[8];
        int    cols[8];
        int    n_ent;
        int    dense[16];
        bit    exp_err;
        bit    stall;
        int    abort_at;
    } case_t;

    int     checks = 0;
    int     errors = 0;
    exp_t   q[$];
    bit     abort;
    int     ent_ready_cycles;
    case_t  tbl[7];

    always @(posedge clk) if (ent_ready) ent_ready_cycles++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string name);
        check(name, {busy, done, err, ptr_ready, ent_ready, out_valid, out_data,
                     out_row, out_col, out_row_last, out_last}, 64'd0);
    endtask

    task automatic run_case(input case_t c);
        int  lim;
        int  first_t;
        int  ptr_sent;
        int  ent_sent;
        exp_t e;
        lim = (c.abort_at > 0) ? c.abort_at : 16;
        first_t = -1;
        ptr_sent = 0;
        ent_sent = 0;
        abort = 1'b0;
        ent_ready_cycles = 0;
        q.delete();
        for (int i = 0; i < 16; i++) begin
            e.data     = 32'(c.dense[i]);
            e.row      = 2'(i / 4);
            e.col      = 2'(i % 4);
            e.row_last = ((i % 4) == 3);
            e.last     = (i == 15);
            q.push_back(e);
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({c.name, "_busy"}, {63'd0, busy}, 64'd1);
        fork
            begin
                bit hs;
                int t;
                for (int k = 0; k < 5; k++) begin
                    if (abort) break;
                    ptr_valid = 1'b1; ptr_data = 16'(c.ptrs[k]);
                    t = 0; hs = 1'b0;
                    forever begin
                        #1 hs = ptr_ready;
                        @(negedge clk); t++;
                        if (hs || abort || t > 300) break;
                    end
                    if (!hs) break;
                    ptr_sent++;
                end
                ptr_valid = 1'b0;
            end
            begin
                bit hs;
                int t;
                for (int k = 0; k < c.n_ent; k++) begin
                    if (abort) break;
                    ent_valid = 1'b1; ent_val = 32'(c.vals[k]); ent_col = 2'(c.cols[k]);
                    t = 0; hs = 1'b0;
                    forever begin
                        #1 hs = ent_ready;
                        @(negedge clk); t++;
                        if (hs || abort || t > 300) break;
                    end
                    if (!hs) break;
                    ent_sent++;
                end
                ent_valid = 1'b0;
            end
            begin
                bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
                exp_t cur, held, ex;
                bit   stalled, rdy;
                int   t, n_out;
                stalled = 1'b0; t = 0; n_out = 0;
                while (n_out < lim && t < 600) begin
                    rdy = c.stall ? pat[t % 4] : 1'b1;
                    out_ready = rdy;
                    #1;
                    cur = {out_data, out_row, out_col, out_row_last, out_last};
                    if (out_valid && first_t < 0) first_t = t;
                    if (stalled && out_valid) check($sformatf("%s_hold%0d", c.name, n_out), 64'(cur), 64'(held));
                    stalled = 1'b0;
                    if (out_valid && rdy) begin
                        ex = q.pop_front();
                        check($sformatf("%s_elem%0d", c.name, n_out), 64'(cur), 64'(ex));
                        n_out++;
                    end else if (out_valid) begin
                        held = cur;
                        stalled = 1'b1;
                    end
                    @(negedge clk); t++;
                end
                check({c.name, "_out_count"}, 64'(n_out), 64'(lim));
                if (c.abort_at > 0) abort = 1'b1;
            end
        join
        if (c.abort_at == 0) begin
            check({c.name, "_done"}, {62'd0, done, busy}, 64'd2);
            check({c.name, "_err"}, {63'd0, err}, {63'd0, c.exp_err});
            check({c.name, "_ptrs_sent"}, 64'(ptr_sent), 64'd5);
            check({c.name, "_ents_sent"}, 64'(ent_sent), 64'(c.n_ent));
            if (c.n_ent == 0) check({c.name, "_no_ent_ready"}, 64'(ent_ready_cycles), 64'd0);
            if (!c.stall) check({c.name, "_latency"}, 64'(first_t), 64'd3);
            @(negedge clk);
            check({c.name, "_done_pulse"}, {63'd0, done}, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{name: "basic", ptrs: '{0, 1, 1, 5, 6},
                   vals: '{5, 1, 2, 3, 4, -7, 0, 0}, cols: '{1, 0, 1, 2, 3, 3, 0, 0}, n_ent: 6,
                   dense: '{0, 5, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 0, 0, 0, -7},
                   exp_err: 1'b0, stall: 1'b0, abort_at: 0};
        tbl[1] = tbl[0]; tbl[1].name = "stall"; tbl[1].stall = 1'b1;
        tbl[2] = '{name: "zero", ptrs: '{0, 0, 0, 0, 0},
                   vals: '{0, 0, 0, 0, 0, 0, 0, 0}, cols: '{0, 0, 0, 0, 0, 0, 0, 0}, n_ent: 0,
                   dense: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   exp_err: 1'b0, stall: 1'b0, abort_at: 0};
        tbl[3] = '{name: "order", ptrs: '{0, 2, 2, 2, 2},
                   vals: '{9, 8, 0, 0, 0, 0, 0, 0}, cols: '{2, 1, 0, 0, 0, 0, 0, 0}, n_ent: 2,
                   dense: '{0, 0, 9, (CHK ? 0 : 8), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   exp_err: CHK, stall: 1'b0, abort_at: 0};
        tbl[4] = '{name: "drain", ptrs: '{0, 3, 3, 3, 3},
                   vals: '{11, 12, 13, 0, 0, 0, 0, 0}, cols: '{0, 3, 3, 0, 0, 0, 0, 0}, n_ent: 3,
                   dense: '{11, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   exp_err: CHK, stall: 1'b0, abort_at: 0};
        tbl[5] = tbl[0]; tbl[5].name = "abort"; tbl[5].abort_at = 7;
        tbl[6] = tbl[0]; tbl[6].name = "resend";

        repeat (3) @(negedge clk);
        check_reset_state("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("reset_state");

        for (int i = 0; i < 7; i++) begin
            run_case(tbl[i]);
            if (tbl[i].abort_at > 0) begin
                ptr_valid = 1'b0; ent_valid = 1'b0; out_ready = 1'b0;
                @(negedge clk); rst_n = 1'b0;
                repeat (2) @(negedge clk);
                check_reset_state("abort_reset");
                rst_n = 1'b1;
                @(negedge clk);
            end
            repeat (2) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
